pcie_perst_seq: RTL and testbench

PCIE_PERST_SEQ -- requirements
Module: pcie_perst_seq

---
 rtl/pcie_seq_pkg.sv | 19 +
 rtl/ons_sync_2ff.sv | 25 ++
 rtl/pcie_perst_seq.sv | 128 ++++++++++++
 tb/tb_pcie_perst_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_seq_pkg.sv
// Shared types and constants for the PCIe slot PERST#/W_DISABLE# sequencer.
// Holds the state encoding, counter width and default cycle budgets at 125 MHz.
// No logic; imported by pcie_perst_seq.
package pcie_seq_pkg;

    localparam int CNT_W                = 24;
    localparam int DEF_PWR_WAIT_CYC     = 12_500_000;
    localparam int DEF_PERST_WAIT_CYC   = 12_500_000;
    localparam int DEF_LOCK_TIMEOUT_CYC = 15_000_000;

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_PERST_HOLD = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAULT      = 3'd4
    } seq_state_t;

endpackage

// File: rtl/ons_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Latency: 2 clock cycles. Backpressure: none, free-running.
// RST_VAL selects the level the flops take during reset.
module ons_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pcie_perst_seq.sv
// PCIe slot power-up sequencer: timed PERST#/W_DISABLE# release gated on MMCM lock.
// Latency: async inputs 2 cycles, outputs registered on the transition edge. No backpressure.
// `define PCIE_SEQ_CLKREQ_EN to also require CLKREQ# low to acquire and hold lock.
module pcie_perst_seq
    import pcie_seq_pkg::*;
#(
    parameter int PWR_WAIT_CYC     = DEF_PWR_WAIT_CYC,
    parameter int PERST_WAIT_CYC   = DEF_PERST_WAIT_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC
) (
    input  logic       bd_fclk0_125m,
    input  logic       bd_sys_rstn,
    input  logic       pcie_dbg_mmcm_lock,
    input  logic       pcie_clkreq_b,
    input  logic       pcie_wake_b,
    input  logic       sw_rst_req,
    output logic       pcie_perst_b,
    output logic       pcie_w_disable_b,
    output logic [2:0] seq_state,
    output logic       seq_fault,
    output logic       wake_evt
);

    localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(PWR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] PERST_LAST = CNT_W'(PERST_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);

    seq_state_t       state;
    seq_state_t       nxt;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;
    logic             wake_s;
    logic             wake_d;
    logic             acq_ok;
    logic             hold_ok;

    ons_sync_2ff #(.RST_VAL(1'b0)) u_sync_lock (
        .clk   (bd_fclk0_125m),
        .rst_n (bd_sys_rstn),
        .d     (pcie_dbg_mmcm_lock),
        .q     (lock_s)
    );

    ons_sync_2ff #(.RST_VAL(1'b1)) u_sync_wake (
        .clk   (bd_fclk0_125m),
        .rst_n (bd_sys_rstn),
        .d     (pcie_wake_b),
        .q     (wake_s)
    );

`ifdef PCIE_SEQ_CLKREQ_EN
    logic clkreq_s;

    ons_sync_2ff #(.RST_VAL(1'b1)) u_sync_clkreq (
        .clk   (bd_fclk0_125m),
        .rst_n (bd_sys_rstn),
        .d     (pcie_clkreq_b),
        .q     (clkreq_s)
    );

    assign acq_ok  = lock_s & ~clkreq_s;
    assign hold_ok = lock_s & ~clkreq_s;
`else
    logic clkreq_unused;

    assign clkreq_unused = pcie_clkreq_b;
    assign acq_ok        = lock_s;
    assign hold_ok       = lock_s;
`endif

    always_comb begin
        nxt = state;
        if (sw_rst_req) begin
            nxt = ST_RESET;
        end else begin
            case (state)
                ST_RESET:      if (cnt == PWR_LAST) nxt = ST_WAIT_LOCK;
                ST_WAIT_LOCK:  begin
                    // Lock arriving on the timeout cycle still wins.
                    if (acq_ok)                 nxt = ST_PERST_HOLD;
                    else if (cnt == LOCK_LAST)  nxt = ST_FAULT;
                end
                ST_PERST_HOLD: begin
                    if (!hold_ok)               nxt = ST_WAIT_LOCK;
                    else if (cnt == PERST_LAST) nxt = ST_RUN;
                end
                ST_RUN:        if (!lock_s) nxt = ST_WAIT_LOCK;
                ST_FAULT:      nxt = ST_FAULT;
                default:       nxt = ST_RESET;
            endcase
        end
    end

    always_ff @(posedge bd_fclk0_125m or negedge bd_sys_rstn) begin
        if (!bd_sys_rstn) begin
            state <= ST_RESET;
            cnt   <= '0;
        end else begin
            state <= nxt;
            // Saturate rather than wrap while parked in RUN or FAULT.
            if (sw_rst_req || (nxt != state)) cnt <= '0;
            else if (cnt != {CNT_W{1'b1}})    cnt <= cnt + 1'b1;
        end
    end

    // Outputs decode the next state so pins move on the transition edge itself.
    always_ff @(posedge bd_fclk0_125m or negedge bd_sys_rstn) begin
        if (!bd_sys_rstn) begin
            pcie_perst_b     <= 1'b0;
            pcie_w_disable_b <= 1'b0;
            seq_fault        <= 1'b0;
            wake_evt         <= 1'b0;
            wake_d           <= 1'b1;
        end else begin
            pcie_perst_b     <= (nxt == ST_RUN);
            pcie_w_disable_b <= (nxt != ST_RESET);
            if (nxt == ST_FAULT)
                seq_fault <= 1'b1;
            else if ((nxt == ST_RESET) && (state != ST_RESET))
                seq_fault <= 1'b0;
            wake_d   <= wake_s;
            wake_evt <= (state == ST_RUN) && wake_d && !wake_s;
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_pcie_perst_seq.sv
// Directed bench for pcie_perst_seq with short cycle budgets (10/20/50).
// Build with +define+PCIE_SEQ_CLKREQ_EN to also exercise the CLKREQ# gating.
module tb_pcie_perst_seq;

    logic       clk;
    logic       rst_n;
    logic       lock;
    logic       clkreq_b;
    logic       wake_b;
    logic       sw_rst_req;
    logic       perst_b;
    logic       w_disable_b;
    logic [2:0] state;
    logic       fault;
    logic       wake_evt;

    int n_cmp = 0;
    int n_bad = 0;

    pcie_perst_seq #(
        .PWR_WAIT_CYC     (10),
        .PERST_WAIT_CYC   (20),
        .LOCK_TIMEOUT_CYC (50)
    ) dut (
        .bd_fclk0_125m      (clk),
        .bd_sys_rstn        (rst_n),
        .pcie_dbg_mmcm_lock (lock),
        .pcie_clkreq_b      (clkreq_b),
        .pcie_wake_b        (wake_b),
        .sw_rst_req         (sw_rst_req),
        .pcie_perst_b       (perst_b),
        .pcie_w_disable_b   (w_disable_b),
        .seq_state          (state),
        .seq_fault          (fault),
        .wake_evt           (wake_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset release lands just after an edge; the next edge is edge 1.
    task automatic do_reset(input logic lock_v);
        rst_n      = 1'b0;
        lock       = lock_v;
        sw_rst_req = 1'b0;
        wake_b     = 1'b1;
        clkreq_b   = 1'b0;
        step(3);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; lock = 1'b1; wake_b = 1'b1; clkreq_b = 1'b0; sw_rst_req = 1'b0;
        step(4);
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_state got=%0d exp=0", state); end
        n_cmp++; if ({perst_b, w_disable_b, fault, wake_evt} !== 4'b0000) begin
            n_bad++; $display("FAIL rst_outs got=%b exp=0000", {perst_b, w_disable_b, fault, wake_evt});
        end
    endtask

    // Lock appears as WAIT_LOCK is entered: 10 + 2 sync + 1 + 20 = 33.
    task automatic test_power_up;
        do_reset(1'b0);
        step(9);
        n_cmp++; if ({state, w_disable_b} !== {3'd0, 1'b0}) begin n_bad++; $display("FAIL pwr_e9 got=%0d/%b exp=0/0", state, w_disable_b); end
        step(1);
        n_cmp++; if ({state, w_disable_b, perst_b} !== {3'd1, 1'b1, 1'b0}) begin n_bad++; $display("FAIL pwr_e10 got=%0d/%b/%b exp=1/1/0", state, w_disable_b, perst_b); end
        lock = 1'b1;
        step(2);
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL pwr_e12 got=%0d exp=1", state); end
        step(1);
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL pwr_e13 got=%0d exp=2", state); end
        step(19);
        n_cmp++; if ({state, perst_b} !== {3'd2, 1'b0}) begin n_bad++; $display("FAIL pwr_e32 got=%0d/%b exp=2/0", state, perst_b); end
        step(1);
        n_cmp++; if ({state, perst_b, w_disable_b} !== {3'd3, 1'b1, 1'b1}) begin n_bad++; $display("FAIL pwr_e33 got=%0d/%b/%b exp=3/1/1", state, perst_b, w_disable_b); end
    endtask

    task automatic test_lock_loss;
        lock = 1'b0;
        step(2);
        n_cmp++; if ({state, perst_b} !== {3'd3, 1'b1}) begin n_bad++; $display("FAIL loss_e2 got=%0d/%b exp=3/1", state, perst_b); end
        step(1);
        n_cmp++; if ({state, perst_b, w_disable_b} !== {3'd1, 1'b0, 1'b1}) begin n_bad++; $display("FAIL loss_e3 got=%0d/%b/%b exp=1/0/1", state, perst_b, w_disable_b); end
        lock = 1'b1;
        step(3);
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL relock_hold got=%0d exp=2", state); end
        step(19);
        n_cmp++; if ({state, perst_b} !== {3'd2, 1'b0}) begin n_bad++; $display("FAIL relock_e19 got=%0d/%b exp=2/0", state, perst_b); end
        step(1);
        n_cmp++; if ({state, perst_b} !== {3'd3, 1'b1}) begin n_bad++; $display("FAIL relock_run got=%0d/%b exp=3/1", state, perst_b); end
    endtask

    task automatic test_wake;
        int pulses;
        int at;
        pulses = 0; at = -1;
        wake_b = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (wake_evt) begin pulses++; if (at < 0) at = i; end
        end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL wake_run_count got=%0d exp=1", pulses); end
        n_cmp++; if (at !== 3) begin n_bad++; $display("FAIL wake_run_lat got=%0d exp=3", at); end
        wake_b = 1'b1;
        lock = 1'b0;
        step(4);
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL wake_to_wait got=%0d exp=1", state); end
        pulses = 0;
        wake_b = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (wake_evt) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL wake_wait_count got=%0d exp=0", pulses); end
        wake_b = 1'b1;
    endtask

    // Lock held from reset: PERST_HOLD at edge 11, glitch 15 edges into it.
    task automatic test_glitch;
        do_reset(1'b1);
        step(11);
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL glitch_hold got=%0d exp=2", state); end
        step(15);
        lock = 1'b0;
        step(3);
        n_cmp++; if ({state, perst_b} !== {3'd1, 1'b0}) begin n_bad++; $display("FAIL glitch_wait got=%0d/%b exp=1/0", state, perst_b); end
        step(2);
        lock = 1'b1;
        step(3);
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL glitch_rehold got=%0d exp=2", state); end
        step(19);
        n_cmp++; if ({state, perst_b} !== {3'd2, 1'b0}) begin n_bad++; $display("FAIL glitch_e19 got=%0d/%b exp=2/0", state, perst_b); end
        step(1);
        n_cmp++; if ({state, perst_b} !== {3'd3, 1'b1}) begin n_bad++; $display("FAIL glitch_run got=%0d/%b exp=3/1", state, perst_b); end
    endtask

    task automatic test_reset_in_run;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({state, perst_b, w_disable_b} !== {3'd0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL async_rst got=%0d/%b/%b exp=0/0/0", state, perst_b, w_disable_b);
        end
        step(2);
    endtask

    task automatic test_fault;
        do_reset(1'b0);
        step(10);
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL flt_wait got=%0d exp=1", state); end
        step(49);
        n_cmp++; if ({state, fault} !== {3'd1, 1'b0}) begin n_bad++; $display("FAIL flt_e59 got=%0d/%b exp=1/0", state, fault); end
        step(1);
        n_cmp++; if ({state, fault, perst_b, w_disable_b} !== {3'd4, 1'b1, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL flt_e60 got=%0d/%b/%b/%b exp=4/1/0/1", state, fault, perst_b, w_disable_b);
        end
        lock = 1'b1;
        step(6);
        n_cmp++; if ({state, fault} !== {3'd4, 1'b1}) begin n_bad++; $display("FAIL flt_sticky got=%0d/%b exp=4/1", state, fault); end
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        n_cmp++; if ({state, fault, w_disable_b, perst_b} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL flt_swrst got=%0d/%b/%b/%b exp=0/0/0/0", state, fault, w_disable_b, perst_b);
        end
        // sw_rst_req while already in RESET restarts the 10-cycle wait.
        step(5);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        step(9);
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL restart_e9 got=%0d exp=0", state); end
        step(1);
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL restart_e10 got=%0d exp=1", state); end
    endtask

    // Synced lock lands exactly on the timeout cycle (counter 49 after edge 59).
    task automatic test_lock_priority;
        do_reset(1'b0);
        step(57);
        lock = 1'b1;
        step(3);
        n_cmp++; if ({state, fault} !== {3'd2, 1'b0}) begin n_bad++; $display("FAIL prio got=%0d/%b exp=2/0", state, fault); end
    endtask

`ifdef PCIE_SEQ_CLKREQ_EN
    task automatic test_clkreq;
        do_reset(1'b1);
        clkreq_b = 1'b1;
        step(20);
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL clkreq_hi got=%0d exp=1", state); end
        clkreq_b = 1'b0;
        step(2);
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL clkreq_e2 got=%0d exp=1", state); end
        step(1);
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL clkreq_hold got=%0d exp=2", state); end
        clkreq_b = 1'b1;
        step(3);
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL clkreq_loss got=%0d exp=1", state); end
    endtask
`endif

    initial begin
        test_reset();
        test_power_up();
        test_lock_loss();
        test_wake();
        test_glitch();
        test_reset_in_run();
        test_fault();
        test_lock_priority();
`ifdef PCIE_SEQ_CLKREQ_EN
        test_clkreq();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
